// File: rtl/host_cmd_bridge.sv
// Byte-link command front end: deserialises read/write frames, issues one memory op, serialises the reply.
// Latency: ISSUE 1 cycle after the last frame byte, reply after WAIT1 + WAIT2; rx/tx handshakes are valid/ready.
module host_cmd_bridge #(
   parameter logic [7:0] CMD_READ  = 8'h01,
   parameter logic [7:0] CMD_WRITE = 8'h02,
   parameter logic [7:0] ACK_BYTE  = 8'hAA,
   parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic [1:0]  o_mem_op,
   output logic [63:0] o_mem_addr,
   output logic [63:0] o_mem_data,
   input  logic [63:0] i_mem_data,
   input  logic        i_mem_op_pending,
   output logic        o_busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_WAIT1 = 3'd4;
   localparam logic [2:0] S_WAIT2 = 3'd5;
   localparam logic [2:0] S_RESP  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   logic [2:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] data_q, data_d;
   logic [63:0] shift_q, shift_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic        rx_xfer;
   logic        tx_xfer;

   assign o_rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
   assign o_tx_valid = (state_q == S_RESP) || (state_q == S_ERR);
   assign o_tx_data  = (state_q == S_ERR) ? ERR_BYTE : shift_q[7:0];
   assign o_mem_op   = (state_q == S_ISSUE) ? (wr_q ? OP_WRITE : OP_READ) : OP_NOP;
   assign o_mem_addr = addr_q;
   assign o_mem_data = data_q;
   assign o_busy     = (state_q != S_IDLE);
   assign rx_xfer    = i_rx_valid && o_rx_ready;
   assign tx_xfer    = o_tx_valid && i_tx_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      shift_d = shift_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         S_IDLE: if (rx_xfer) begin
            if (i_rx_data == CMD_READ || i_rx_data == CMD_WRITE) begin
               wr_d    = (i_rx_data == CMD_WRITE);
               cnt_d   = 3'd0;
               state_d = S_ADDR;
            end else begin
               state_d = S_ERR;
            end
         end
         S_ADDR: if (rx_xfer) begin
            addr_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = wr_q ? S_DATA : S_ISSUE;
         end
         S_DATA: if (rx_xfer) begin
            data_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = S_ISSUE;
         end
         S_ISSUE: state_d = S_WAIT1;
         // Downstream pending flag is registered, so it cannot be trusted until WAIT2.
         S_WAIT1: state_d = S_WAIT2;
         S_WAIT2: if (!i_mem_op_pending) begin
            state_d = S_RESP;
            if (wr_q) begin
               shift_d = {56'd0, ACK_BYTE};
               rcnt_d  = 4'd1;
            end else begin
               shift_d = i_mem_data;
               rcnt_d  = 4'd8;
            end
         end
         S_RESP: if (tx_xfer) begin
            shift_d = {8'd0, shift_q[63:8]};
            rcnt_d  = rcnt_q - 4'd1;
            if (rcnt_q == 4'd1) state_d = S_IDLE;
         end
         S_ERR: if (tx_xfer) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         wr_q    <= 1'b0;
         addr_q  <= 64'd0;
         data_q  <= 64'd0;
         shift_q <= 64'd0;
         rcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         shift_q <= shift_d;
         rcnt_q  <= rcnt_d;
      end
   end

endmodule

// File: tb/tb_host_cmd_bridge.sv
// Randomised bench for host_cmd_bridge: a model of the compute top level answers memory ops,
// a reference model predicts ops and reply bytes into queues, and a monitor pops and compares them.
module tb_host_cmd_bridge;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [7:0]  i_rx_data = 8'd0;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b1;
   logic [1:0]  o_mem_op;
   logic [63:0] o_mem_addr;
   logic [63:0] o_mem_data;
   logic [63:0] i_mem_data;
   logic        i_mem_op_pending;
   logic        o_busy;

   host_cmd_bridge dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_mem_op(o_mem_op), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .i_mem_data(i_mem_data), .i_mem_op_pending(i_mem_op_pending), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   // Compute top level: op latched on the issue edge, pending high one cycle later for memory,
   // register space (bit 63) answers at once with the halted flag and never raises pending.
   logic [63:0] env_mem [logic [63:0]];
   logic        s1_vld = 1'b0;
   logic [1:0]  s1_op, s2_op;
   logic [63:0] s1_a, s1_d, s2_a, s2_d;
   logic [63:0] env_rd = 64'd0;
   logic        env_pend = 1'b0;
   assign i_mem_data = env_rd;
   assign i_mem_op_pending = env_pend;

   always @(posedge i_clk) begin
      s1_vld <= (o_mem_op != 2'd0);
      s1_op  <= o_mem_op;
      s1_a   <= o_mem_addr;
      s1_d   <= o_mem_data;
      if (o_mem_op == 2'd1 && o_mem_addr[63]) env_rd <= 64'd1;
      if (s1_vld && !s1_a[63]) begin
         env_pend <= 1'b1;
         s2_op <= s1_op;
         s2_a  <= s1_a;
         s2_d  <= s1_d;
      end
      if (env_pend) begin
         env_pend <= 1'b0;
         if (s2_op == 2'd2) env_mem[s2_a] = s2_d;
         else env_rd <= env_mem.exists(s2_a) ? env_mem[s2_a] : 64'd0;
      end
   end

   // Reference model and scoreboard queues.
   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] d;
   } op_t;
   op_t         exp_op [$];
   logic [7:0]  exp_tx [$];
   logic [63:0] ref_mem [logic [63:0]];
   logic [63:0] last_d = 64'd0;

   function automatic logic [63:0] ref_read(input logic [63:0] a);
      if (a[63]) return 64'd1;
      return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
   endfunction

   // Link-side ready pattern: 0 always ready, 1 random, 2 one ready cycle then five stalled.
   int rdy_mode = 0;
   int rdy_ctr = 0;
   always @(posedge i_clk) begin
      #1;
      rdy_ctr++;
      case (rdy_mode)
         0: i_tx_ready = 1'b1;
         1: i_tx_ready = 1'($urandom_range(0, 1));
         default: i_tx_ready = (rdy_ctr % 6 == 0);
      endcase
   end

   logic       held_vld = 1'b0;
   logic [7:0] held_dat = 8'd0;
   always @(negedge i_clk) begin
      if (i_rst) begin
         held_vld = 1'b0;
      end else begin
         if (o_mem_op != 2'd0) begin
            if (exp_op.size() == 0) begin
               check("unexpected_mem_op", {62'd0, o_mem_op}, 64'd0);
            end else begin
               op_t e;
               e = exp_op.pop_front();
               check("mem_op", {62'd0, o_mem_op}, {62'd0, e.op});
               check("mem_addr", o_mem_addr, e.a);
               check("mem_data", o_mem_data, e.d);
            end
         end
         if (o_tx_valid && held_vld) check("tx_stable", {56'd0, o_tx_data}, {56'd0, held_dat});
         held_vld = o_tx_valid && !i_tx_ready;
         held_dat = o_tx_data;
         if (o_tx_valid && i_tx_ready) begin
            if (exp_tx.size() == 0) check("unexpected_tx", {56'd0, o_tx_data}, 64'hFFFF);
            else check("tx_byte", {56'd0, o_tx_data}, {56'd0, exp_tx.pop_front()});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      repeat (gap) begin
         @(posedge i_clk);
         #1;
      end
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         if (o_rx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
      if (!ok) timeout_fail("rx_handshake");
   endtask

   task automatic send_cmd(input logic [7:0] opc, input logic [63:0] a, input logic [63:0] d, input int gmax);
      send_byte(opc, $urandom_range(0, gmax));
      if (opc == 8'h01 || opc == 8'h02) begin
         for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8], $urandom_range(0, gmax));
         if (opc == 8'h02) for (int i = 0; i < 8; i++) send_byte(d[8*i +: 8], $urandom_range(0, gmax));
         if (opc == 8'h02) begin
            last_d = d;
            ref_mem[a] = d;
            exp_op.push_back('{2'd2, a, d});
            exp_tx.push_back(8'hAA);
         end else begin
            logic [63:0] r;
            r = ref_read(a);
            exp_op.push_back('{2'd1, a, last_d});
            for (int i = 0; i < 8; i++) exp_tx.push_back(r[8*i +: 8]);
         end
      end else begin
         exp_tx.push_back(8'hEE);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_tx.size() != 0 || o_busy) && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      @(posedge i_clk);
      #1;
      if (n >= 3000) timeout_fail("drain");
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] d;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_busy", {63'd0, o_busy}, 64'd0);
      check("rst_mem_op", {62'd0, o_mem_op}, 64'd0);
      check("rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
      check("rst_tx_data", {56'd0, o_tx_data}, 64'd0);
      check("rst_mem_addr", o_mem_addr, 64'd0);
      check("rst_mem_data", o_mem_data, 64'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      send_cmd(8'h02, 64'h10, 64'h1122334455667788, 0);
      drain();
      send_cmd(8'h01, 64'h10, 64'd0, 0);
      drain();
      send_cmd(8'h01, 64'h8000_0000_0000_0000, 64'd0, 0);
      drain();
      send_cmd(8'h5A, 64'd0, 64'd0, 0);
      drain();
      send_cmd(8'h01, 64'h10, 64'd0, 0);
      drain();

      rdy_mode = 2;
      send_cmd(8'h01, 64'h10, 64'd0, 3);
      drain();
      rdy_mode = 0;

      // Abort a frame after four address bytes.
      send_byte(8'h02, 0);
      for (int i = 0; i < 4; i++) send_byte(8'h33, 0);
      i_rst = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("abort_busy", {63'd0, o_busy}, 64'd0);
      check("abort_mem_op", {62'd0, o_mem_op}, 64'd0);
      check("abort_tx_valid", {63'd0, o_tx_valid}, 64'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      last_d = 64'd0;
      send_cmd(8'h02, 64'h18, 64'hCAFE_F00D_0BAD_BEEF, 1);
      drain();

      rdy_mode = 1;
      for (int k = 0; k < 24; k++) begin
         int r;
         r = $urandom_range(0, 9);
         a = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
         d = {$urandom, $urandom};
         if (r <= 3) send_cmd(8'h02, a, d, 2);
         else if (r <= 6 || r == 9) send_cmd(8'h01, a, 64'd0, 2);
         else if (r == 7) send_cmd(8'h01, 64'h8000_0000_0000_0000, 64'd0, 2);
         else send_cmd(8'($urandom_range(3, 255)), 64'd0, 64'd0, 2);
      end
      drain();
      rdy_mode = 0;

      check("ops_outstanding", 64'(exp_op.size()), 64'd0);
      check("tx_outstanding", 64'(exp_tx.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
